// File: rtl/ram8_seq_ctrl.sv
// rtl/ram8_seq_ctrl.sv - RAM8 fill + readback-verify sequencer (self-test engine)
// Optional: RAM8_SEQ_ERRCNT_EN adds err_count and a full read sweep on mismatch.
module ram8_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern_base,
    input  logic [WIDTH-1:0] pattern_step,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [AW-1:0]    err_addr,
`ifdef RAM8_SEQ_ERRCNT_EN
    output logic [AW:0]      err_count,
`endif
    output logic             ram_load,
    output logic [AW-1:0]    ram_address,
    output logic [WIDTH-1:0] ram_in,
    input  logic [WIDTH-1:0] ram_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    state_t           state;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] expected_next;
    logic             mismatch;
    logic             finish_read;

    // Running accumulator: base + idx*step, wrapping modulo 2^WIDTH.
    assign expected_next = expected + step_q;
    assign mismatch      = (state == S_READ) && (ram_out != expected);

`ifdef RAM8_SEQ_ERRCNT_EN
    assign finish_read = (idx == LAST);
`else
    // Without the counter the pass is cut short at the first bad word.
    assign finish_read = (idx == LAST) || mismatch;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            expected    <= '0;
            base_q      <= '0;
            step_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_addr    <= '0;
`ifdef RAM8_SEQ_ERRCNT_EN
            err_count   <= '0;
`endif
            ram_load    <= 1'b0;
            ram_address <= '0;
            ram_in      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_q      <= pattern_base;
                        step_q      <= pattern_step;
                        expected    <= pattern_base;
                        idx         <= '0;
                        error       <= 1'b0;
                        err_addr    <= '0;
`ifdef RAM8_SEQ_ERRCNT_EN
                        err_count   <= '0;
`endif
                        state       <= S_WRITE;
                        busy        <= 1'b1;
                        ram_load    <= 1'b1;
                        ram_address <= '0;
                        ram_in      <= pattern_base;
                    end
                end

                S_WRITE: begin
                    if (idx == LAST) begin
                        state       <= S_READ;
                        idx         <= '0;
                        expected    <= base_q;
                        ram_load    <= 1'b0;
                        ram_address <= '0;
                        ram_in      <= '0;
                    end else begin
                        idx         <= idx + 1'b1;
                        expected    <= expected_next;
                        ram_address <= idx + 1'b1;
                        ram_in      <= expected_next;
                    end
                end

                S_READ: begin
                    if (mismatch) begin
`ifdef RAM8_SEQ_ERRCNT_EN
                        err_count <= err_count + 1'b1;
`endif
                        if (!error) begin
                            error    <= 1'b1;
                            err_addr <= idx;
                        end
                    end
                    if (finish_read) begin
                        state       <= S_DONE;
                        idx         <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        ram_address <= '0;
                    end else begin
                        idx         <= idx + 1'b1;
                        expected    <= expected_next;
                        ram_address <= idx + 1'b1;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    ram_load    <= 1'b0;
                    ram_address <= '0;
                    ram_in      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_seq_ctrl.sv
// tb/tb_ram8_seq_ctrl.sv - directed bench for ram8_seq_ctrl driving a behavioural RAM8
module tb_ram8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern_base = '0;
    logic [15:0] pattern_step = '0;
    logic        busy, done, error;
    logic [2:0]  err_addr;
    logic        ram_load;
    logic [2:0]  ram_address;
    logic [15:0] ram_in, ram_out;
    logic        fault_en = 1'b0;
    logic [15:0] mem [8];
`ifdef RAM8_SEQ_ERRCNT_EN
    logic [3:0]  err_count;
    localparam int FAULT_DONE = 17;
`else
    localparam int FAULT_DONE = 15;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ram8_seq_ctrl #(.WIDTH(16), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pattern_base(pattern_base), .pattern_step(pattern_step),
        .busy(busy), .done(done), .error(error), .err_addr(err_addr),
`ifdef RAM8_SEQ_ERRCNT_EN
        .err_count(err_count),
`endif
        .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in),
        .ram_out(ram_out)
    );

    // RAM8: synchronous write, combinational read; contents survive reset.
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
    assign ram_out = mem[ram_address] ^
        ((fault_en && busy && !ram_load && ram_address == 3'd5) ? 16'h0001 : 16'h0000);

    task automatic run_pass(input logic [15:0] b, input logic [15:0] s,
                            output int done_cyc, output int done_cnt,
                            output int busy_first, output int busy_last, output int busy_cnt);
        done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
        @(negedge clk);
        pattern_base = b; pattern_step = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pattern_base = ~b; pattern_step = ~s;
        for (int c = 1; c <= 24; c++) begin
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                done_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, error, err_addr, ram_load, ram_address, ram_in} !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, error, err_addr, ram_load, ram_address, ram_in});
        end
`ifdef RAM8_SEQ_ERRCNT_EN
        total++;
        if (err_count !== 4'd0) begin bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        int dc, dn, bf, bl, bn;
        logic [15:0] exp_t [8];
        exp_t = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        run_pass(16'h1111, 16'h1111, dc, dn, bf, bl, bn);
        total++; if (bf !== 1)  begin bad++; $display("FAIL fill_busy_first: got %0d want 1", bf); end
        total++; if (bl !== 16) begin bad++; $display("FAIL fill_busy_last: got %0d want 16", bl); end
        total++; if (bn !== 16) begin bad++; $display("FAIL fill_busy_cnt: got %0d want 16", bn); end
        total++; if (dc !== 17) begin bad++; $display("FAIL fill_done_cycle: got %0d want 17", dc); end
        total++; if (dn !== 1)  begin bad++; $display("FAIL fill_done_cnt: got %0d want 1", dn); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL fill_error: got %b want 0", error); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[i] !== exp_t[i]) begin bad++; $display("FAIL fill_mem%0d: got %h want %h", i, mem[i], exp_t[i]); end
        end
    endtask

    task automatic test_wrap();
        int dc, dn, bf, bl, bn;
        run_pass(16'hFFFF, 16'h0001, dc, dn, bf, bl, bn);
        total++; if (mem[0] !== 16'hFFFF) begin bad++; $display("FAIL wrap_mem0: got %h want FFFF", mem[0]); end
        total++; if (mem[1] !== 16'h0000) begin bad++; $display("FAIL wrap_mem1: got %h want 0000", mem[1]); end
        total++; if (mem[7] !== 16'h0006) begin bad++; $display("FAIL wrap_mem7: got %h want 0006", mem[7]); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL wrap_error: got %b want 0", error); end
        total++; if (dc !== 17) begin bad++; $display("FAIL wrap_done_cycle: got %0d want 17", dc); end
    endtask

    task automatic test_fault();
        int dc, dn, bf, bl, bn;
        fault_en = 1'b1;
        run_pass(16'h0000, 16'h0001, dc, dn, bf, bl, bn);
        fault_en = 1'b0;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL fault_error: got %b want 1", error); end
        total++; if (err_addr !== 3'd5) begin bad++; $display("FAIL fault_err_addr: got %0d want 5", err_addr); end
        total++; if (dc !== FAULT_DONE) begin bad++; $display("FAIL fault_done_cycle: got %0d want %0d", dc, FAULT_DONE); end
        total++; if (dn !== 1) begin bad++; $display("FAIL fault_done_cnt: got %0d want 1", dn); end
`ifdef RAM8_SEQ_ERRCNT_EN
        total++; if (err_count !== 4'd1) begin bad++; $display("FAIL fault_err_count: got %0d want 1", err_count); end
`endif
    endtask

    task automatic test_ignore_start();
        int dc = 100;
        int dc2 = -1;
        int dn = 0;
        fault_en = 1'b1;
        @(negedge clk);
        pattern_base = 16'h0000; pattern_step = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (done) begin
                dn++;
                if (dc == 100) dc = c;
                else if (dc2 < 0) dc2 = c;
            end
            if (c == dc + 1) begin
                fault_en = 1'b0;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy_after_done: got %b want 0", busy); end
                total++; if (error !== 1'b1) begin bad++; $display("FAIL ign_error_held: got %b want 1", error); end
            end
            if (c == dc + 2) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_restart_busy: got %b want 1", busy); end
                total++; if (error !== 1'b0) begin bad++; $display("FAIL ign_error_cleared: got %b want 0", error); end
            end
            start = (c == 3) || done || (c == dc + 1);
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (dc !== FAULT_DONE) begin bad++; $display("FAIL ign_done_cycle: got %0d want %0d", dc, FAULT_DONE); end
        total++; if (dn !== 2) begin bad++; $display("FAIL ign_done_cnt: got %0d want 2", dn); end
        total++; if (dc2 !== dc + 18) begin bad++; $display("FAIL ign_second_done: got %0d want %0d", dc2, dc + 18); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL ign_final_error: got %b want 0", error); end
    endtask

    task automatic test_step0();
        int dc, dn, bf, bl, bn;
        run_pass(16'hABCD, 16'h0000, dc, dn, bf, bl, bn);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[i] !== 16'hABCD) begin bad++; $display("FAIL step0_mem%0d: got %h want ABCD", i, mem[i]); end
        end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL step0_error: got %b want 0", error); end
        total++; if (dc !== 17) begin bad++; $display("FAIL step0_done_cycle: got %0d want 17", dc); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_t [8];
        exp_t = '{16'h1000, 16'h1100, 16'h1200, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD};
        @(negedge clk);
        pattern_base = 16'h1000; pattern_step = 16'h0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ram_load, ram_address} !== 4'b1011) begin
            bad++; $display("FAIL rst_mid_pre: got load/addr %b want 1011", {ram_load, ram_address});
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, error, err_addr, ram_load, ram_address, ram_in} !== 26'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h want 0",
                     {busy, done, error, err_addr, ram_load, ram_address, ram_in});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_idle: got busy %b want 0", busy); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[i] !== exp_t[i]) begin bad++; $display("FAIL rst_mid_mem%0d: got %h want %h", i, mem[i], exp_t[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_fault();
        test_ignore_start();
        test_step0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
